fpu_sp_mul: RTL and testbench

//  IEEE-754 binary32 multiplier: the Fmul datapath of the single-precision FPU in the user project area.

---
 rtl/fpu_sp_mul.sv | 256 +++++++++++++++++++++++++
 tb/tb_fpu_sp_mul.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fpu_sp_mul.sv
// IEEE-754 binary32 multiplier, fixed 3-stage pipeline, RISC-V rounding modes and fflags.
// Define FPU_MUL_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module fpu_sp_mul (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        in_valid_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [2:0]  rm_i,
    output logic        out_valid_o,
    output logic [31:0] result_o,
    output logic [4:0]  fflags_o
);

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_t;

    typedef struct packed {
        logic        zero;
        logic        inf;
        logic        nan;
        logic        snan;
        logic [23:0] mant;
        logic [9:0]  ex;
    } opnd_t;

    localparam logic [31:0] QNAN = 32'h7FC00000;

`ifdef FPU_MUL_SUBNORMAL_EN
    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        n = 5'd24;
        for (int unsigned i = 0; i < 24; i++) begin
            if (m[i]) n = 5'(23 - i);
        end
        return n;
    endfunction
`endif

    // Mantissa always leaves here with its leading one at bit 23.
    function automatic opnd_t unpack(input logic [31:0] x);
        opnd_t       o;
        logic [7:0]  e;
        logic [22:0] f;
`ifdef FPU_MUL_SUBNORMAL_EN
        logic [4:0]  lz;
`endif
        e      = x[30:23];
        f      = x[22:0];
        o.nan  = (e == 8'hFF) && (f != '0);
        o.snan = o.nan && !f[22];
        o.inf  = (e == 8'hFF) && (f == '0);
`ifdef FPU_MUL_SUBNORMAL_EN
        o.zero = (e == '0) && (f == '0);
        if (e == '0) begin
            lz     = lzc24({1'b0, f});
            o.mant = {1'b0, f} << lz;
            o.ex   = 10'd1 - {5'd0, lz};
        end else begin
            o.mant = {1'b1, f};
            o.ex   = {2'b00, e};
        end
`else
        o.zero = (e == '0);
        o.mant = {1'b1, f};
        o.ex   = {2'b00, e};
`endif
        return o;
    endfunction

    // ---------------- stage 1: unpack, classify, exponent sum
    opnd_t              ua, ub;
    logic               c1_sign, c1_spec, c1_nv;
    logic [31:0]        c1_spec_res;
    logic signed [9:0]  c1_exp;

    always_comb begin
        ua          = unpack(op_a_i);
        ub          = unpack(op_b_i);
        c1_sign     = op_a_i[31] ^ op_b_i[31];
        c1_spec     = 1'b1;
        c1_nv       = 1'b0;
        c1_spec_res = QNAN;
        if (ua.snan || ub.snan || (ua.inf && ub.zero) || (ua.zero && ub.inf)) begin
            c1_nv = 1'b1;
        end else if (ua.nan || ub.nan) begin
            c1_spec_res = QNAN;
        end else if (ua.inf || ub.inf) begin
            c1_spec_res = {c1_sign, 8'hFF, 23'd0};
        end else if (ua.zero || ub.zero) begin
            c1_spec_res = {c1_sign, 31'd0};
        end else begin
            c1_spec = 1'b0;
        end
        c1_exp = $signed(ua.ex) + $signed(ub.ex) - 10'sd127;
    end

    logic               s1_valid, s1_sign, s1_spec, s1_nv;
    rm_t                s1_rm;
    logic [31:0]        s1_spec_res;
    logic signed [9:0]  s1_exp;
    logic [23:0]        s1_ma, s1_mb;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_spec     <= 1'b0;
            s1_nv       <= 1'b0;
            s1_rm       <= RM_RNE;
            s1_spec_res <= '0;
            s1_exp      <= '0;
            s1_ma       <= '0;
            s1_mb       <= '0;
        end else begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_sign     <= c1_sign;
                s1_spec     <= c1_spec;
                s1_nv       <= c1_nv;
                s1_rm       <= (rm_i > 3'd4) ? RM_RNE : rm_t'(rm_i);
                s1_spec_res <= c1_spec_res;
                s1_exp      <= c1_exp;
                s1_ma       <= ua.mant;
                s1_mb       <= ub.mant;
            end
        end
    end

    // ---------------- stage 2: mantissa product, single-step normalize
    logic [47:0]        c2_prod, c2_mant;
    logic signed [9:0]  c2_exp;

    always_comb begin
        c2_prod = s1_ma * s1_mb;
        if (c2_prod[47]) begin
            c2_mant = c2_prod;
            c2_exp  = s1_exp + 10'sd1;
        end else begin
            c2_mant = c2_prod << 1;
            c2_exp  = s1_exp;
        end
    end

    logic               s2_valid, s2_sign, s2_spec, s2_nv;
    rm_t                s2_rm;
    logic [31:0]        s2_spec_res;
    logic signed [9:0]  s2_exp;
    logic [47:0]        s2_mant;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_spec     <= 1'b0;
            s2_nv       <= 1'b0;
            s2_rm       <= RM_RNE;
            s2_spec_res <= '0;
            s2_exp      <= '0;
            s2_mant     <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign     <= s1_sign;
                s2_spec     <= s1_spec;
                s2_nv       <= s1_nv;
                s2_rm       <= s1_rm;
                s2_spec_res <= s1_spec_res;
                s2_exp      <= c2_exp;
                s2_mant     <= c2_mant;
            end
        end
    end

    // ---------------- stage 3: round, renormalize, pack, flags
    logic               c3_tiny, c3_g, c3_st, c3_inexact, c3_inc, c3_carry;
    logic signed [9:0]  c3_diff, c3_exp_r;
    logic [5:0]         c3_sh;
    logic [95:0]        c3_wide;
    logic [23:0]        c3_kept;
    logic [24:0]        c3_rounded;
    logic [31:0]        c3_res, c3_max, c3_inf;
    logic [4:0]         c3_flags;

    always_comb begin
        c3_tiny = (s2_exp < 10'sd1);
        c3_diff = 10'sd1 - s2_exp;
        // Shifts beyond 50 only move more bits into sticky, so clamping is exact.
        if (!c3_tiny)              c3_sh = 6'd0;
        else if (c3_diff > 10'sd50) c3_sh = 6'd50;
        else                        c3_sh = c3_diff[5:0];
        c3_wide    = {s2_mant, 48'd0} >> c3_sh;
        c3_kept    = c3_wide[95:72];
        c3_g       = c3_wide[71];
        c3_st      = |c3_wide[70:0];
        c3_inexact = c3_g | c3_st;
        case (s2_rm)
            RM_RNE:  c3_inc = c3_g & (c3_st | c3_kept[0]);
            RM_RTZ:  c3_inc = 1'b0;
            RM_RDN:  c3_inc = s2_sign & c3_inexact;
            RM_RUP:  c3_inc = !s2_sign & c3_inexact;
            RM_RMM:  c3_inc = c3_g;
            default: c3_inc = c3_g & (c3_st | c3_kept[0]);
        endcase
        c3_rounded = {1'b0, c3_kept} + {24'd0, c3_inc};
        c3_carry   = c3_rounded[24];
        c3_exp_r   = s2_exp + $signed({9'd0, c3_carry});
        c3_max     = {s2_sign, 8'hFE, 23'h7FFFFF};
        c3_inf     = {s2_sign, 8'hFF, 23'd0};

        if (s2_spec) begin
            c3_res   = s2_spec_res;
            c3_flags = {s2_nv, 4'b0000};
        end else if (c3_tiny) begin
`ifdef FPU_MUL_SUBNORMAL_EN
            // A round-up into bit 23 lands exactly on the smallest normal.
            c3_res   = {s2_sign, 7'd0, c3_rounded[23], c3_rounded[22:0]};
            c3_flags = {3'b000, c3_inexact, c3_inexact};
`else
            c3_res   = {s2_sign, 31'd0};
            c3_flags = 5'b00011;
`endif
        end else if (c3_exp_r >= 10'sd255) begin
            case (s2_rm)
                RM_RTZ:  c3_res = c3_max;
                RM_RDN:  c3_res = s2_sign ? c3_inf : c3_max;
                RM_RUP:  c3_res = s2_sign ? c3_max : c3_inf;
                default: c3_res = c3_inf;
            endcase
            c3_flags = 5'b00101;
        end else begin
            c3_res   = {s2_sign, c3_exp_r[7:0], c3_carry ? 23'd0 : c3_rounded[22:0]};
            c3_flags = {4'b0000, c3_inexact};
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_valid_o <= 1'b0;
            result_o    <= '0;
            fflags_o    <= '0;
        end else begin
            out_valid_o <= s2_valid;
            if (s2_valid) begin
                result_o <= c3_res;
                fflags_o <= c3_flags;
            end
        end
    end

endmodule

// File: tb/tb_fpu_sp_mul.sv
// Directed-vector bench for fpu_sp_mul: latency, rounding, overflow, specials, underflow, reset flush.
module tb_fpu_sp_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [2:0]  rm = '0;
    logic        out_valid;
    logic [31:0] result;
    logic [4:0]  fflags;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] exp_res_q[$];
    logic [4:0]  exp_flg_q[$];
    string       exp_tag_q[$];
    logic [2:0]  vpipe = '0;

    always #5 clk = ~clk;

    fpu_sp_mul dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .in_valid_i  (in_valid),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .rm_i        (rm),
        .out_valid_o (out_valid),
        .result_o    (result),
        .fflags_o    (fflags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Expected valid: exactly three edges after sampling.
    always @(posedge clk or posedge rst) begin
        if (rst) vpipe <= '0;
        else     vpipe <= {vpipe[1:0], in_valid};
    end

    always @(negedge clk) begin
        check("out_valid", {31'd0, out_valid}, {31'd0, vpipe[2]});
        if (out_valid) begin
            check("pending", 32'(exp_res_q.size() != 0), 32'd1);
            if (exp_res_q.size() != 0) begin
                check({exp_tag_q[0], ".res"}, result, exp_res_q[0]);
                check({exp_tag_q[0], ".flags"}, {27'd0, fflags}, {27'd0, exp_flg_q[0]});
                void'(exp_res_q.pop_front());
                void'(exp_flg_q.pop_front());
                void'(exp_tag_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] mode,
                         input logic [31:0] want, input logic [4:0] wflags, input string tag,
                         input bit track);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        rm       = mode;
        if (track) begin
            exp_res_q.push_back(want);
            exp_flg_q.push_back(wflags);
            exp_tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        check("rst.result", result, 32'h0);
        check("rst.flags", {27'd0, fflags}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // flags are {NV,DZ,OF,UF,NX}
        issue(32'h40400000, 32'h40000000, 3'd0, 32'h40C00000, 5'b00000, "3x2", 1);
        idle(4);
        issue(32'hBFC00000, 32'h40800000, 3'd0, 32'hC0C00000, 5'b00000, "m1.5x4", 1);
        issue(32'h3FC00000, 32'h3FC00000, 3'd0, 32'h40100000, 5'b00000, "1.5sq", 1);
        issue(32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'b00001, "rnd_rne", 1);
        issue(32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'b00001, "rnd_rup", 1);
        issue(32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 5'b00001, "rnd_rtz", 1);
        issue(32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800002, 5'b00001, "rnd_rdn_pos", 1);
        issue(32'hBF800001, 32'h3F800001, 3'd2, 32'hBF800003, 5'b00001, "rnd_rdn_neg", 1);
        issue(32'h3F800001, 32'h3F800001, 3'd6, 32'h3F800002, 5'b00001, "rnd_rm6", 1);
        issue(32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 5'b00001, "tie_rne", 1);
        issue(32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 5'b00001, "tie_rmm", 1);
        issue(32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 5'b00101, "ovf_rne", 1);
        issue(32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, 5'b00101, "ovf_rtz", 1);
        issue(32'h7F000000, 32'h7F000000, 3'd4, 32'h7F800000, 5'b00101, "ovf_rmm", 1);
        issue(32'hFF000000, 32'h7F000000, 3'd2, 32'hFF800000, 5'b00101, "ovf_rdn_neg", 1);
        issue(32'hFF000000, 32'h7F000000, 3'd3, 32'hFF7FFFFF, 5'b00101, "ovf_rup_neg", 1);
        issue(32'h7F000000, 32'h7F000000, 3'd2, 32'h7F7FFFFF, 5'b00101, "ovf_rdn_pos", 1);
        issue(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000, "inf_x_0", 1);
        issue(32'h7FA00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000, "snan", 1);
        issue(32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000, "qnan", 1);
        issue(32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'b00000, "ninf_x_2", 1);
        issue(32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 5'b00000, "nzero_x_2", 1);
`ifdef FPU_MUL_SUBNORMAL_EN
        issue(32'h00800000, 32'h3F000000, 3'd0, 32'h00400000, 5'b00000, "sub_exact", 1);
        issue(32'h00800001, 32'h3F000000, 3'd0, 32'h00400000, 5'b00011, "sub_tie", 1);
        issue(32'h00000001, 32'h3F800000, 3'd0, 32'h00000001, 5'b00000, "sub_in", 1);
`else
        issue(32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 5'b00011, "sub_exact", 1);
        issue(32'h00800001, 32'h3F000000, 3'd0, 32'h00000000, 5'b00011, "sub_tie", 1);
        issue(32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 5'b00000, "sub_in", 1);
`endif
        idle(6);
        check("drain1", exp_res_q.size(), 32'd0);

        // Two ops in flight, then reset: neither may emerge.
        issue(32'h40400000, 32'h40000000, 3'd0, 32'h0, 5'b0, "flush_a", 0);
        issue(32'h3FC00000, 32'h3FC00000, 3'd0, 32'h0, 5'b0, "flush_b", 0);
        rst = 1'b1;
        #1;
        check("rst_async.valid", {31'd0, out_valid}, 32'd0);
        check("rst_async.result", result, 32'h0);
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst.valid", {31'd0, out_valid}, 32'd0);
        end
        #1;
        issue(32'h40400000, 32'h40000000, 3'd0, 32'h40C00000, 5'b00000, "recover", 1);
        idle(6);
        check("drain2", exp_res_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
